// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART: register offsets, UCON bit
// positions and the state encoding used by both the RX and TX sequencers.
package uart_pkg;

  localparam logic [31:0] TXD_OFS  = 32'd0;
  localparam logic [31:0] RXD_OFS  = 32'd4;
  localparam logic [31:0] UCON_OFS = 32'd8;

  localparam int unsigned UCON_RX_IRQ_EN  = 0;
  localparam int unsigned UCON_TX_IRQ_EN  = 1;
  localparam int unsigned UCON_RX_VALID   = 2;
  localparam int unsigned UCON_TX_BUSY    = 3;
  localparam int unsigned UCON_TX_FULL    = 4;
  localparam int unsigned UCON_RX_OVERRUN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Reloadable bit-period down-counter. tick pulses exactly DIV (or DIV/2 when
// loaded with half) clocks after the load cycle, then the timer idles.
module uart_bit_timer #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic half,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL_RELOAD = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'((DIV / 2 > 0) ? (DIV / 2 - 1) : 0);
  localparam logic [CW-1:0] ONE         = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  assign tick = run_q && (cnt_q == '0);

  // A load issued on the tick cycle restarts the period seamlessly.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    if (load) begin
      cnt_d = half ? HALF_RELOAD : FULL_RELOAD;
      run_d = 1'b1;
    end else if (tick) begin
      run_d = 1'b0;
    end else if (run_q) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART: TXD/RXD/UCON registers on the CPU peripheral bus, a
// bit-timed RX deserializer and TX serializer, each with a one-deep holding reg.
module uart_mmio_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic        UART_RX,
  output logic        UART_TX,
  output logic        irq
);

  localparam int unsigned DIV = CLK_FREQ / BAUD;

  // Bus access: mem_read/mem_write are single-cycle strobes, qualified by hit;
  // every register side effect lands on the sys_clk edge ending that cycle.
  logic sel_txd, sel_rxd, sel_ucon;
  logic txd_write, rxd_read, ucon_write;

  assign sel_txd    = (addr == BASE_ADDR + TXD_OFS);
  assign sel_rxd    = (addr == BASE_ADDR + RXD_OFS);
  assign sel_ucon   = (addr == BASE_ADDR + UCON_OFS);
  assign hit        = sel_txd | sel_rxd | sel_ucon;
  assign txd_write  = mem_write & sel_txd;
  assign rxd_read   = mem_read & sel_rxd;
  assign ucon_write = mem_write & sel_ucon;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  uart_state_e rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  logic [2:0]  rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d, rx_hold_q, rx_hold_d;
  logic [7:0]  tx_shift_q, tx_shift_d, tx_hold_q, tx_hold_d;
  logic        rx_valid_q, rx_valid_d, rx_overrun_q, rx_overrun_d;
  logic        tx_full_q, tx_full_d, tx_line_q, tx_line_d;
  logic        rx_irq_en_q, rx_irq_en_d, tx_irq_en_q, tx_irq_en_d;
  logic        rx_load, rx_half, rx_tick, rx_commit, rx_drop, rx_fall;
  logic        tx_load, tx_tick, tx_take, tx_busy;

  uart_bit_timer #(.DIV(DIV)) u_rx_timer (
    .clk(sys_clk), .rst(reset), .load(rx_load), .half(rx_half), .tick(rx_tick)
  );

  uart_bit_timer #(.DIV(DIV)) u_tx_timer (
    .clk(sys_clk), .rst(reset), .load(tx_load), .half(1'b0), .tick(tx_tick)
  );

  assign rx_fall = rx_prev_q & ~rx_s2_q;
  assign tx_busy = (tx_state_q != ST_IDLE);
  assign UART_TX = tx_line_q;
  assign irq     = (rx_valid_q & rx_irq_en_q) | (~tx_full_q & ~tx_busy & tx_irq_en_q);

  always_comb begin
    rdata = '0;
    if (sel_rxd) begin
      rdata = {24'b0, rx_hold_q};
    end else if (sel_ucon) begin
      rdata[UCON_RX_IRQ_EN]  = rx_irq_en_q;
      rdata[UCON_TX_IRQ_EN]  = tx_irq_en_q;
      rdata[UCON_RX_VALID]   = rx_valid_q;
      rdata[UCON_TX_BUSY]    = tx_busy;
      rdata[UCON_TX_FULL]    = tx_full_q;
      rdata[UCON_RX_OVERRUN] = rx_overrun_q;
    end
  end

  // RX sequencer: START is timed at half a bit so later samples hit mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_load    = 1'b0;
    rx_half    = 1'b0;
    rx_commit  = 1'b0;
    rx_drop    = 1'b0;
    case (rx_state_q)
      ST_IDLE: if (rx_fall) begin
        rx_state_d = ST_START;
        rx_bit_d   = '0;
        rx_load    = 1'b1;
        rx_half    = 1'b1;
      end
      ST_START: if (rx_tick) begin
        if (!rx_s2_q) begin
          rx_state_d = ST_DATA;
          rx_load    = 1'b1;
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_DATA: if (rx_tick) begin
        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        rx_load    = 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      end
      ST_STOP: if (rx_tick) begin
        rx_state_d = ST_IDLE;
        // A same-cycle RXD read frees the holding register for the new byte.
        if (rx_s2_q) begin
          if (rx_valid_q && !rxd_read) rx_drop = 1'b1;
          else rx_commit = 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rx_hold_d    = rx_hold_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = rx_overrun_q;
    rx_irq_en_d  = rx_irq_en_q;
    tx_irq_en_d  = tx_irq_en_q;
    if (rxd_read) rx_valid_d = 1'b0;
    if (rx_commit) begin
      rx_hold_d  = rx_shift_q;
      rx_valid_d = 1'b1;
    end
    if (ucon_write) begin
      rx_irq_en_d = wdata[UCON_RX_IRQ_EN];
      tx_irq_en_d = wdata[UCON_TX_IRQ_EN];
      if (wdata[UCON_RX_OVERRUN]) rx_overrun_d = 1'b0;
    end
    if (rx_drop) rx_overrun_d = 1'b1;
  end

  // TX sequencer: the line is registered from the next state to stay glitch-free.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    tx_load    = 1'b0;
    tx_take    = 1'b0;
    case (tx_state_q)
      ST_IDLE: if (tx_full_q) begin
        tx_shift_d = tx_hold_q;
        tx_take    = 1'b1;
        tx_load    = 1'b1;
        tx_state_d = ST_START;
      end
      ST_START: if (tx_tick) begin
        tx_bit_d   = '0;
        tx_load    = 1'b1;
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_tick) begin
        tx_bit_d   = tx_bit_q + 3'd1;
        tx_load    = 1'b1;
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
      end
      ST_STOP: if (tx_tick) tx_state_d = ST_IDLE;
      default: tx_state_d = ST_IDLE;
    endcase
    if (tx_take) tx_full_d = 1'b0;
    if (txd_write && (!tx_full_q || tx_take)) begin
      tx_hold_d = wdata[7:0];
      tx_full_d = 1'b1;
    end
    case (tx_state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      rx_hold_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_irq_en_q  <= 1'b0;
      tx_irq_en_q  <= 1'b0;
      tx_state_q   <= ST_IDLE;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_hold_q    <= '0;
      tx_full_q    <= 1'b0;
      tx_line_q    <= 1'b1;
    end else begin
      rx_s1_q      <= UART_RX;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
      rx_state_q   <= rx_state_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      rx_hold_q    <= rx_hold_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      rx_irq_en_q  <= rx_irq_en_d;
      tx_irq_en_q  <= tx_irq_en_d;
      tx_state_q   <= tx_state_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_hold_q    <= tx_hold_d;
      tx_full_q    <= tx_full_d;
      tx_line_q    <= tx_line_d;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboard bench for uart_mmio_ctrl: CPU reads and serial TX frames are
// checked against a register-level model of the UART kept in this file.
module tb_uart_mmio_ctrl;

  localparam int unsigned CLK_FREQ = 1600;
  localparam int unsigned BAUD     = 100;
  localparam int DIV = CLK_FREQ / BAUD;
  localparam logic [31:0] A_TXD  = 32'h40000018;
  localparam logic [31:0] A_RXD  = 32'h4000001C;
  localparam logic [31:0] A_UCON = 32'h40000020;
  // Stop-bit sample cycle, counted from the cycle the start bit is driven:
  // two synchronizer stages, half a bit, then eight data bits and the stop bit.
  localparam int COMMIT_CYC = 2 + DIV / 2 + 9 * DIV;

  logic        sys_clk, reset;
  logic [31:0] addr, wdata, rdata;
  logic        mem_write, mem_read, hit;
  logic        uart_rx, uart_tx, irq;

  uart_mmio_ctrl #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BASE_ADDR(A_TXD)) dut (
    .sys_clk(sys_clk), .reset(reset), .addr(addr), .wdata(wdata),
    .mem_write(mem_write), .mem_read(mem_read), .rdata(rdata), .hit(hit),
    .UART_RX(uart_rx), .UART_TX(uart_tx), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [32:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  int frames_seen = 0;
  int last_end = -1;
  int last_gap = -1;

  logic       m_rx_valid, m_overrun, m_rx_en, m_tx_en, m_tx_pending, m_tx_busy;
  logic [7:0] m_rx_hold;

  task automatic model_reset();
    m_rx_valid = 0; m_overrun = 0; m_rx_en = 0; m_tx_en = 0;
    m_tx_pending = 0; m_tx_busy = 0; m_rx_hold = 8'h00;
  endtask

  function automatic logic [31:0] model_ucon();
    return {26'b0, m_overrun, m_tx_pending, m_tx_busy, m_rx_valid, m_tx_en, m_rx_en};
  endfunction

  function automatic logic [31:0] model_irq();
    return {31'b0, (m_rx_valid & m_rx_en) | (~m_tx_pending & ~m_tx_busy & m_tx_en)};
  endfunction

  function automatic logic is_reg(input logic [31:0] a);
    return (a == A_TXD) || (a == A_RXD) || (a == A_UCON);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic cpu_read(input logic [31:0] a);
    logic [31:0] e;
    e = 32'h0;
    if (a == A_RXD) e = {24'b0, m_rx_hold};
    else if (a == A_UCON) e = model_ucon();
    exp_rd_q.push_back({is_reg(a), e});
    if (a == A_RXD) m_rx_valid = 0;
    addr = a;
    mem_read = 1'b1;
    @(posedge sys_clk); #1;
    mem_read = 1'b0;
    addr = 32'h0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    mem_write = 1'b1;
    #2;
    check("write_hit", {31'b0, hit}, {31'b0, is_reg(a)});
    if (a == A_TXD && !m_tx_pending) begin
      m_tx_pending = 1;
      exp_tx_q.push_back(d[7:0]);
    end
    if (a == A_UCON) begin
      m_rx_en = d[0];
      m_tx_en = d[1];
      if (d[5]) m_overrun = 0;
    end
    @(posedge sys_clk); #1;
    mem_write = 1'b0;
    addr = 32'h0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      repeat (DIV) @(posedge sys_clk);
      #1;
    end
    uart_rx = 1'b1;
    if (stop_bit) begin
      if (m_rx_valid) m_overrun = 1;
      else begin
        m_rx_hold = b;
        m_rx_valid = 1;
      end
    end
    idle(4);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frames_seen < n && t < 2000) begin
      @(posedge sys_clk); #1;
      t++;
    end
    checks++;
    if (frames_seen < n) begin
      failures++;
      $display("FAIL tx_timeout actual=%0d required=%0d frames", frames_seen, n);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : rd_mon
    logic [32:0] e;
    forever begin
      @(negedge sys_clk);
      if (mem_read) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL read_unexpected actual=0x%0h required=no_read", rdata);
        end else begin
          e = exp_rd_q.pop_front();
          check("read_hit", {31'b0, hit}, {31'b0, e[32]});
          check("read_data", rdata, e[31:0]);
        end
      end
    end
  end

  initial begin : tx_mon
    logic [9:0] fr, act;
    logic       ok, aborted;
    int         start_cyc;
    forever begin
      @(negedge sys_clk);
      if (!reset && uart_tx === 1'b0) begin
        start_cyc = cyc;
        if (exp_tx_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL tx_unexpected_frame actual=frame required=idle cycle=%0d", cyc);
          repeat (10 * DIV) @(negedge sys_clk);
        end else begin
          fr = {1'b1, exp_tx_q.pop_front(), 1'b0};
          act = '0;
          ok = 1; aborted = 0;
          m_tx_busy = 1; m_tx_pending = 0;
          if (last_end >= 0) last_gap = start_cyc - last_end;
          for (int i = 0; i < 10 * DIV; i++) begin
            if (i > 0) @(negedge sys_clk);
            if (reset) begin
              aborted = 1;
              break;
            end
            if (i % DIV == DIV / 2) act[i / DIV] = uart_tx;
            if (uart_tx !== fr[i / DIV]) ok = 0;
          end
          m_tx_busy = 0;
          if (!aborted) begin
            checks++;
            if (!ok) begin
              failures++;
              $display("FAIL tx_frame actual=0b%b required=0b%b", act, fr);
            end
            frames_seen++;
            last_end = cyc + 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [7:0]  b;
    logic [31:0] a;
    reset = 1'b1; addr = '0; wdata = '0; mem_write = 0; mem_read = 0; uart_rx = 1'b1;
    model_reset();
    #2;
    check("reset_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    repeat (3) @(posedge sys_clk); #1;
    reset = 1'b0;
    idle(2);
    cpu_read(A_UCON);
    cpu_read(A_RXD);
    cpu_read(A_TXD);

    // basic receive, then read clears rx_valid
    send_rx(8'h40, 1'b1);
    cpu_read(A_UCON);
    cpu_read(A_RXD);
    cpu_read(A_UCON);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      send_rx(b, 1'b1);
      cpu_read(A_RXD);
    end

    // framing error: byte discarded, old hold kept
    send_rx(8'($urandom_range(0, 255)), 1'b0);
    cpu_read(A_UCON);
    cpu_read(A_RXD);

    // overrun and write-1-to-clear
    send_rx(8'h40, 1'b1);
    send_rx(8'h10, 1'b1);
    cpu_read(A_UCON);
    cpu_read(A_RXD);
    cpu_write(A_UCON, 32'h20);
    cpu_read(A_UCON);

    // glitch shorter than half a bit
    uart_rx = 1'b0;
    idle(DIV / 2);
    uart_rx = 1'b1;
    idle(200);
    cpu_read(A_UCON);
    b = 8'($urandom_range(0, 255));
    send_rx(b, 1'b1);
    cpu_read(A_RXD);

    // RXD read in the exact stop-commit cycle
    send_rx(8'h40, 1'b1);
    fork
      send_rx(8'h10, 1'b1);
      begin
        repeat (COMMIT_CYC) @(posedge sys_clk);
        #1;
        cpu_read(A_RXD);
      end
    join
    cpu_read(A_UCON);
    cpu_read(A_RXD);

    // interrupt enables
    cpu_write(A_UCON, 32'h1);
    check("irq_rx_en_empty", {31'b0, irq}, model_irq());
    send_rx(8'($urandom_range(0, 255)), 1'b1);
    check("irq_rx_byte", {31'b0, irq}, model_irq());
    cpu_read(A_RXD);
    check("irq_after_read", {31'b0, irq}, model_irq());
    cpu_write(A_UCON, 32'h2);
    check("irq_tx_idle", {31'b0, irq}, model_irq());
    cpu_write(A_UCON, 32'h0);
    check("irq_disabled", {31'b0, irq}, model_irq());

    // back-to-back transmit, third write dropped while holding reg is full
    cpu_write(A_TXD, 32'h55);
    idle(5);
    cpu_write(A_TXD, 32'hA3);
    cpu_write(A_TXD, {24'h0, 8'($urandom_range(0, 255))});
    cpu_read(A_UCON);
    wait_frames(2);
    check("tx_back_to_back_gap", last_gap, 32'd1);
    cpu_read(A_UCON);
    for (int i = 0; i < 2; i++) begin
      cpu_write(A_TXD, $urandom);
      wait_frames(frames_seen + 1);
    end

    // accesses that miss the register map
    cpu_write(A_TXD + 32'd12, $urandom);
    cpu_read(A_TXD + 32'd12);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      if (is_reg(a)) a = a ^ 32'h100;
      cpu_write(a, $urandom);
      cpu_read(a);
    end
    idle(30);
    cpu_read(A_UCON);

    // reset in the middle of a transmit frame
    cpu_write(A_UCON, 32'h3);
    cpu_write(A_TXD, {24'h0, 8'($urandom_range(0, 255))});
    idle(50);
    reset = 1'b1;
    #1;
    check("reset_mid_tx_line", {31'b0, uart_tx}, 32'd1);
    check("reset_mid_tx_irq", {31'b0, irq}, 32'd0);
    exp_tx_q.delete();
    model_reset();
    repeat (3) @(posedge sys_clk); #1;
    reset = 1'b0;
    idle(2);
    cpu_read(A_UCON);
    check("post_reset_irq", {31'b0, irq}, 32'd0);
    idle(200);

    check("rd_queue_drained", exp_rd_q.size(), 32'd0);
    check("tx_queue_drained", exp_tx_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
